mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported main memory between instruction fetch (stage 1) and
//  load/store data access (stage 4) of the 5-stage pipeline. Data has priority
//  (older instruction); a defer counter bounds fetch starvation. Sequences each
//  access through a wait-state memory handshake and returns one-cycle completion
//  pulses that the pipeline control FSM uses to stall or advance stages.
// PARAMETERS
//  ADDR_W     8   memory address width
//  DATA_W     8   memory data width
//  MAX_DEFER  2   consecutive fetch losses before fetch is forced to win (>=1)
//  TIMEOUT    15  busy cycles without mem_ready before abort (MEM_TIMEOUT_EN only)
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  if_req     in   1       fetch request; held until if_done
//  if_addr    in   ADDR_W  fetch address (PC)
//  if_done    out  1       one-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction, held until next fetch completes
//  if_stall   out  1       combinational: if_req & ~if_done
//  d_req      in   1       data request; held until d_done
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_done     out  1       one-cycle pulse: data access complete
//  d_rdata    out  DATA_W  load data, held until next load completes
//  d_stall    out  1       combinational: d_req & ~d_done
//  err        out  1       one-cycle pulse with a done: access aborted on timeout
//  mem_addr   out  ADDR_W  registered memory address
//  mem_rd     out  1       registered read strobe
//  mem_wr     out  1       registered write strobe
//  mem_wdata  out  DATA_W  registered write data
//  mem_rdata  in   DATA_W  memory read data, valid when mem_ready=1
//  mem_ready  in   1       memory completes the current strobe this cycle
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs, defer and timeout counters, if_rdata, d_rdata = 0.
//    Reset mid-access drops mem_rd/mem_wr immediately; no done pulse is issued.
//  - States: IDLE, F_BUSY, D_BUSY.
//  - IDLE grant, evaluated each cycle: if if_req & defer==MAX_DEFER -> fetch;
//    else if d_req -> data; else if if_req -> fetch; else stay.
//    On grant, register mem_addr/mem_wdata and strobe; go to F_BUSY/D_BUSY.
//    Fetch always drives mem_rd. Data drives mem_wr if d_we, else mem_rd.
//  - defer: +1 (saturating at MAX_DEFER) on each data grant while if_req=1;
//    cleared on a fetch grant. Unchanged otherwise.
//  - BUSY: strobe and address held. On mem_ready=1: drop strobe, capture mem_rdata
//    (reads only), pulse the matching done next cycle, return to IDLE.
//  - Latency: request seen in IDLE at cycle 0, strobe at cycle 1. With mem_ready=1
//    at cycle 1, done at cycle 2. Each wait state adds one cycle.
//    IDLE may grant a new request in the same cycle its done pulse is high,
//    giving back-to-back throughput of 1 access per 2 cycles.
//  - A req deasserted while its access is BUSY is ignored; the access completes.
//  - Requester inputs are sampled only at grant; later changes have no effect.
//  - if_done and d_done are never high in the same cycle. Stores leave d_rdata unchanged.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: a busy counter counts cycles in F_BUSY/D_BUSY with
//    mem_ready=0. When it reaches TIMEOUT, the strobe drops and the access ends as
//    if completed: done and err pulse together, captured rdata=0, state returns to IDLE.
//  MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; err tied to 0.
// TESTING
//  1. Fetch only: if_req=1, if_addr=0x10, mem_ready=1, mem_rdata=0xA5 -> mem_rd at
//     cycle 1, if_done at cycle 2, if_rdata=0xA5.
//  2. Collision: if_req and d_req (load 0x20) both high at cycle 0 -> data served
//     first (d_done at cycle 2), fetch granted at cycle 2 (if_done at cycle 4).
//  3. Starvation, MAX_DEFER=2: if_req held, d_req held for 3 accesses -> grants are
//     D, D, F, D; defer is 0 after the fetch grant.
//  4. Store with 3 wait states: d_we=1, d_addr=0x30, d_wdata=0x5C -> mem_wr high for
//     4 cycles, d_done at cycle 5, d_rdata unchanged.
//  5. Reset asserted in D_BUSY -> mem_wr=0 immediately, state IDLE, no d_done; a
//     fetch after reset completes normally.
//  6. MEM_TIMEOUT_EN, TIMEOUT=15, mem_ready held 0 -> d_done and err pulse together,
//     d_rdata=0, then the next request is granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Optional busy timeout is enabled by defining MEM_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no access in flight; grant data, fetch or nothing this cycle
// F_BUSY | fetch strobe on the memory, waiting for mem_ready
// D_BUSY | load/store strobe on the memory, waiting for mem_ready
module mem_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_DEFER = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int DEF_W = $clog2(MAX_DEFER + 1);
  localparam logic [DEF_W-1:0] DEFER_MAX = DEF_W'(MAX_DEFER);

  if (MAX_DEFER < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_port_arbiter: MAX_DEFER and TIMEOUT must both be >= 1");
  end

  typedef enum logic [1:0] {IDLE, F_BUSY, D_BUSY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic                if_done_q, if_done_d;
  logic                d_done_q, d_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic [DEF_W-1:0]    defer_q, defer_d;
  logic                finish, abort;
  logic [DATA_W-1:0]   rdata_in;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    defer_d     = defer_q;
    finish      = 1'b0;
    abort       = 1'b0;
    rdata_in    = mem_rdata;
`ifdef MEM_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Fetch wins when starved, or when data is not asking.
        if (if_req && (defer_q == DEFER_MAX || !d_req)) begin
          state_d    = F_BUSY;
          mem_addr_d = if_addr;
          mem_rd_d   = 1'b1;
          mem_wr_d   = 1'b0;
          defer_d    = '0;
        end else if (d_req) begin
          state_d     = D_BUSY;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wr_d    = d_we;
          mem_rd_d    = !d_we;
          if (if_req && defer_q != DEFER_MAX) defer_d = defer_q + 1'b1;
        end
`ifdef MEM_TIMEOUT_EN
        tmo_d = TMO_W'(TIMEOUT);
`endif
      end
      default: begin
        if (mem_ready) begin
          finish = 1'b1;
`ifdef MEM_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(1)) begin
          finish = 1'b1;
          abort  = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
`endif
        end
        if (finish) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (abort) rdata_in = '0;
          if (state_q == F_BUSY) begin
            if_done_d  = 1'b1;
            if_rdata_d = rdata_in;
          end else begin
            d_done_d = 1'b1;
            if (mem_rd_q) d_rdata_d = rdata_in;
          end
`ifdef MEM_TIMEOUT_EN
          err_d = abort;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      defer_q     <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      defer_q     <= defer_d;
`ifdef MEM_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_done_q;
  assign d_stall   = d_req & ~d_done_q;
`ifdef MEM_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle plus
// directed scenarios with literal expectations. MEM_TIMEOUT_EN selects the timeout case.
module tb_mem_port_arbiter;

  localparam int MAX_DEFER = 2;
  localparam int TIMEOUT   = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       if_req = 1'b0;
  logic [7:0] if_addr = '0;
  logic       if_done;
  logic [7:0] if_rdata;
  logic       if_stall;
  logic       d_req = 1'b0;
  logic       d_we = 1'b0;
  logic [7:0] d_addr = '0;
  logic [7:0] d_wdata = '0;
  logic       d_done;
  logic [7:0] d_rdata;
  logic       d_stall;
  logic       err;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(8), .MAX_DEFER(MAX_DEFER), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall), .err(err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Model: one access in flight at most; outputs follow from the access record.
  logic       m_busy = 0, m_fetch = 0, m_store = 0;
  logic       m_rd = 0, m_wr = 0, m_if_done = 0, m_d_done = 0, m_err = 0;
  logic [7:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;
  int         m_defer = 0, m_wait = 0;

  task automatic m_complete(input logic [7:0] val, input logic e);
    m_busy = 0; m_rd = 0; m_wr = 0; m_err = e;
    if (m_fetch) begin
      m_if_done = 1; m_if_rdata = val;
    end else begin
      m_d_done = 1;
      if (!m_store) m_d_rdata = val;
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_fetch = 0; m_store = 0; m_rd = 0; m_wr = 0;
      m_if_done = 0; m_d_done = 0; m_err = 0; m_addr = 0; m_wdata = 0;
      m_if_rdata = 0; m_d_rdata = 0; m_defer = 0; m_wait = 0;
    end else begin
      m_if_done = 0; m_d_done = 0; m_err = 0;
      if (m_busy) begin
        if (mem_ready) m_complete(mem_rdata, 1'b0);
        else begin
          m_wait++;
`ifdef MEM_TIMEOUT_EN
          if (m_wait == TIMEOUT) m_complete(8'h00, 1'b1);
`endif
        end
      end else if (if_req && (m_defer == MAX_DEFER || !d_req)) begin
        m_busy = 1; m_fetch = 1; m_store = 0; m_wait = 0;
        m_addr = if_addr; m_rd = 1; m_wr = 0; m_defer = 0;
      end else if (d_req) begin
        m_busy = 1; m_fetch = 0; m_store = d_we; m_wait = 0;
        m_addr = d_addr; m_wdata = d_wdata; m_wr = d_we; m_rd = !d_we;
        if (if_req && m_defer < MAX_DEFER) m_defer++;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (!reset) begin
      chk("m_mem_addr", mem_addr, m_addr);
      chk("m_mem_rd", mem_rd, m_rd);
      chk("m_mem_wr", mem_wr, m_wr);
      if (m_wr) chk("m_mem_wdata", mem_wdata, m_wdata);
      chk("m_if_done", if_done, m_if_done);
      chk("m_d_done", d_done, m_d_done);
      chk("m_if_rdata", if_rdata, m_if_rdata);
      chk("m_d_rdata", d_rdata, m_d_rdata);
      chk("m_err", err, m_err);
      chk("m_if_stall", if_stall, if_req & ~m_if_done);
      chk("m_d_stall", d_stall, d_req & ~m_d_done);
    end
  end

  string log_s;
  int    n_d, wr_cnt, rd_cnt, done_cyc;
  logic  ok;

  initial begin
    cyc(); cyc();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_err", err, 0);
    reset = 0;
    cyc();

    // fetch only, zero wait states
    if_req = 1; if_addr = 8'h10; mem_ready = 1; mem_rdata = 8'hA5;
    cyc();
    chk("t1_mem_rd", mem_rd, 1);
    chk("t1_mem_addr", mem_addr, 8'h10);
    chk("t1_stall", if_stall, 1);
    cyc();
    chk("t1_if_done", if_done, 1);
    chk("t1_if_rdata", if_rdata, 8'hA5);
    chk("t1_stall_off", if_stall, 0);
    if_req = 0;
    cyc();
    chk("t1_idle", mem_rd, 0);

    // collision: data first, then fetch granted in the data done cycle
    if_req = 1; if_addr = 8'h40; d_req = 1; d_we = 0; d_addr = 8'h20; mem_rdata = 8'h3C;
    cyc();
    chk("t2_d_addr", mem_addr, 8'h20);
    chk("t2_d_rd", mem_rd, 1);
    cyc();
    chk("t2_d_done", d_done, 1);
    chk("t2_if_done_low", if_done, 0);
    chk("t2_d_rdata", d_rdata, 8'h3C);
    d_req = 0; mem_rdata = 8'h77;
    cyc();
    chk("t2_f_addr", mem_addr, 8'h40);
    cyc();
    chk("t2_if_done", if_done, 1);
    chk("t2_if_rdata", if_rdata, 8'h77);
    if_req = 0;
    cyc();

    // starvation bound: D, D, F, D
    log_s = ""; n_d = 0; ok = 0;
    if_req = 1; if_addr = 8'h50; d_req = 1; d_we = 0; d_addr = 8'h60; mem_rdata = 8'h99;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (if_done) begin log_s = {log_s, "F"}; if_req = 0; end
      if (d_done) begin
        log_s = {log_s, "D"}; n_d++;
        if (n_d == 3) d_req = 0;
      end
      if (!if_req && !d_req) begin ok = 1; break; end
    end
    chk("t3_finished", ok, 1);
    total++;
    if (log_s != "DDFD") begin
      bad++;
      $display("FAIL t3_order: got %s expected DDFD", log_s);
    end
    chk("t3_model_defer", m_defer, 0);
    cyc();

    // store with three wait states
    d_req = 1; d_we = 1; d_addr = 8'h30; d_wdata = 8'h5C; mem_ready = 0;
    wr_cnt = 0; done_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (d_done) begin done_cyc = i + 1; break; end
      if (mem_wr) begin
        wr_cnt++;
        chk("t4_wdata", mem_wdata, 8'h5C);
        chk("t4_addr", mem_addr, 8'h30);
      end
      if (i == 3) begin mem_ready = 1; mem_rdata = 8'hEE; end
    end
    chk("t4_done_cycle", done_cyc, 5);
    chk("t4_wr_cycles", wr_cnt, 4);
    chk("t4_d_rdata_kept", d_rdata, 8'h99);
    chk("t4_wr_off", mem_wr, 0);
    d_req = 0; d_we = 0;
    cyc();

    // reset during a data access
    d_req = 1; d_we = 1; d_addr = 8'h31; d_wdata = 8'h12; mem_ready = 0;
    cyc();
    chk("t5_wr_on", mem_wr, 1);
    cyc();
    reset = 1; d_req = 0; d_we = 0;
    #1;
    chk("t5_wr_drop", mem_wr, 0);
    chk("t5_addr_clr", mem_addr, 0);
    chk("t5_no_done", d_done, 0);
    cyc();
    chk("t5_no_done2", d_done, 0);
    reset = 0;
    cyc();
    chk("t5_no_done3", d_done, 0);
    if_req = 1; if_addr = 8'h22; mem_ready = 1; mem_rdata = 8'h5A;
    cyc();
    chk("t5_f_rd", mem_rd, 1);
    cyc();
    chk("t5_if_done", if_done, 1);
    chk("t5_if_rdata", if_rdata, 8'h5A);
    if_req = 0;
    cyc();

`ifdef MEM_TIMEOUT_EN
    // timeout abort on a load that never gets mem_ready
    d_req = 1; d_we = 0; d_addr = 8'h44; mem_ready = 0; mem_rdata = 8'hFF;
    rd_cnt = 0; done_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (d_done) begin
        done_cyc = i + 1;
        chk("t6_err", err, 1);
        chk("t6_d_rdata", d_rdata, 0);
        break;
      end
      if (mem_rd) rd_cnt++;
    end
    chk("t6_done_cycle", done_cyc, TIMEOUT + 1);
    chk("t6_rd_cycles", rd_cnt, TIMEOUT);
    d_req = 0;
    if_req = 1; if_addr = 8'h23; mem_ready = 1; mem_rdata = 8'h11;
    cyc();
    chk("t6_next_grant", mem_rd, 1);
    cyc();
    chk("t6_next_done", if_done, 1);
    chk("t6_err_low", err, 0);
    if_req = 0;
    cyc();
`endif

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
